// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue: push side, resolve side, predictor update
// and redirect. The stat_* counters exist only when BRQ_STATS_EN is defined.
interface branch_resolve_queue_if #(
  parameter int W_BRID = 2,
  parameter int W_ADDR = 32,
  parameter int W_PTR  = 2
);
  logic              push_v_i;
  logic              push_pred_i;
  logic [W_BRID-1:0] push_pred_id_i;
  logic [W_ADDR-1:0] push_pc_i;
  logic              full_o;
  logic              empty_o;
  logic [W_PTR:0]    count_o;
  logic              res_v_i;
  logic              res_taken_i;
  logic [W_ADDR-1:0] res_target_i;
  logic              upd_v_o;
  logic              upd_branch_o;
  logic [W_BRID-1:0] upd_branch_id_o;
  logic              flush_o;
  logic [W_ADDR-1:0] redirect_pc_o;
`ifdef BRQ_STATS_EN
  logic [31:0]       stat_res_o;
  logic [31:0]       stat_miss_o;
`endif

  modport slave (
    input  push_v_i, push_pred_i, push_pred_id_i, push_pc_i,
    input  res_v_i, res_taken_i, res_target_i,
    output full_o, empty_o, count_o,
    output upd_v_o, upd_branch_o, upd_branch_id_o, flush_o, redirect_pc_o
`ifdef BRQ_STATS_EN
    , output stat_res_o, stat_miss_o
`endif
  );

  modport master (
    output push_v_i, push_pred_i, push_pred_id_i, push_pc_i,
    output res_v_i, res_taken_i, res_target_i,
    input  full_o, empty_o, count_o,
    input  upd_v_o, upd_branch_o, upd_branch_id_o, flush_o, redirect_pc_o
`ifdef BRQ_STATS_EN
    , input stat_res_o, stat_miss_o
`endif
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; pops on resolve, updates the predictor and
// flushes/redirects fetch on mispredict. Define BRQ_STATS_EN to add pop/mispredict counters.
module branch_resolve_queue #(
  parameter int W_BRID = 2,
  parameter int W_ADDR = 32,
  parameter int DEPTH  = 4,
  parameter int W_PTR  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_queue_if.slave brq
);
  typedef struct packed {
    logic              pred;
    logic [W_BRID-1:0] pred_id;
    logic [W_ADDR-1:0] pc;
  } entry_t;

  localparam logic [W_PTR:0] DEPTH_C = (W_PTR+1)'(DEPTH);

  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [W_PTR-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [W_PTR:0]    count_q, count_d;
  logic              full, empty, pop, push, mispredict;
  logic              upd_v_q, upd_v_d, upd_branch_q, upd_branch_d, flush_q, flush_d;
  logic [W_BRID-1:0] upd_branch_id_q, upd_branch_id_d;
  logic [W_ADDR-1:0] redirect_pc_q, redirect_pc_d;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    pop        = brq.res_v_i & ~empty;
    mispredict = pop & (brq.res_taken_i != head.pred);
    // A mispredicting resolve means anything fetched this cycle is wrong-path.
    push       = brq.push_v_i & ~full & ~mispredict;
  end

  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    upd_v_d         = pop;
    upd_branch_d    = upd_branch_q;
    upd_branch_id_d = upd_branch_id_q;
    flush_d         = mispredict;
    redirect_pc_d   = redirect_pc_q;
    if (pop) begin
      upd_branch_d    = brq.res_taken_i;
      upd_branch_id_d = head.pred_id;
    end
    if (mispredict) begin
      rd_ptr_d      = wr_ptr_q;
      count_d       = '0;
      redirect_pc_d = brq.res_taken_i ? brq.res_target_i : head.pc;
    end else begin
      rd_ptr_d = rd_ptr_q + W_PTR'(pop);
      wr_ptr_d = wr_ptr_q + W_PTR'(push);
      count_d  = count_q + (W_PTR+1)'(push) - (W_PTR+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      upd_v_q         <= 1'b0;
      upd_branch_q    <= 1'b0;
      upd_branch_id_q <= '0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      upd_v_q         <= upd_v_d;
      upd_branch_q    <= upd_branch_d;
      upd_branch_id_q <= upd_branch_id_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  // Entry storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pred: brq.push_pred_i, pred_id: brq.push_pred_id_i, pc: brq.push_pc_i};
    end
  end

  assign brq.full_o          = full;
  assign brq.empty_o         = empty;
  assign brq.count_o         = count_q;
  assign brq.upd_v_o         = upd_v_q;
  assign brq.upd_branch_o    = upd_branch_q;
  assign brq.upd_branch_id_o = upd_branch_id_q;
  assign brq.flush_o         = flush_q;
  assign brq.redirect_pc_o   = redirect_pc_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_res_q, stat_res_d, stat_miss_q, stat_miss_d;

  always_comb begin
    stat_res_d  = stat_res_q + 32'(pop);
    stat_miss_d = stat_miss_q + 32'(mispredict);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_res_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_res_q  <= stat_res_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign brq.stat_res_o  = stat_res_q;
  assign brq.stat_miss_o = stat_miss_q;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: stimulus pushes the expected predictor update for
// every resolve it issues, an independent monitor pops and compares whenever upd_v_o fires.
module tb_branch_resolve_queue;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    logic        branch;
    logic [1:0]  id;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  branch_resolve_queue_if #(.W_BRID(2), .W_ADDR(32), .W_PTR(2)) bus ();

  branch_resolve_queue #(.W_BRID(2), .W_ADDR(32), .DEPTH(4), .W_PTR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .brq   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic idle_inputs();
    bus.push_v_i       = 1'b0;
    bus.push_pred_i    = 1'b0;
    bus.push_pred_id_i = 2'b00;
    bus.push_pc_i      = 32'h0;
    bus.res_v_i        = 1'b0;
    bus.res_taken_i    = 1'b0;
    bus.res_target_i   = 32'h0;
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic pv, input logic pp, input logic [1:0] pid, input logic [31:0] ppc,
                       input logic rv, input logic rt, input logic [31:0] tgt);
    bus.push_v_i       = pv;
    bus.push_pred_i    = pp;
    bus.push_pred_id_i = pid;
    bus.push_pc_i      = ppc;
    bus.res_v_i        = rv;
    bus.res_taken_i    = rt;
    bus.res_target_i   = tgt;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_upd(input logic br, input logic [1:0] id, input logic fl, input logic [31:0] pc);
    exp_t e;
    e.branch = br;
    e.id     = id;
    e.flush  = fl;
    e.pc     = pc;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.upd_v_o) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_upd: got upd_v_o=1 expected no update");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("upd_branch", 32'(bus.upd_branch_o), 32'(e.branch));
          chk("upd_branch_id", 32'(bus.upd_branch_id_o), 32'(e.id));
          chk("flush", 32'(bus.flush_o), 32'(e.flush));
          if (e.flush) chk("redirect_pc", bus.redirect_pc_o, e.pc);
        end
      end else if (bus.flush_o) begin
        total++;
        bad++;
        $display("FAIL stray_flush: got flush_o=1 without upd_v_o expected 0");
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle_inputs();
    tick(2);
    // 1: reset state
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_upd_v", 32'(bus.upd_v_o), 32'd0);
    chk("rst_flush", 32'(bus.flush_o), 32'd0);
    chk("rst_redirect", bus.redirect_pc_o, 32'h0);
    reset = 1'b0;
    tick(1);

    // 2: fill, overflow push dropped, drain with correct predictions
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'b10, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0);
    chk("fill_full", 32'(bus.full_o), 32'd1);
    chk("fill_count", 32'(bus.count_o), 32'd4);
    drive(1'b1, 1'b1, 2'b01, 32'h1FF, 1'b0, 1'b0, 32'h0);
    chk("overflow_count", 32'(bus.count_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      expect_upd(1'b1, 2'b10, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h0);
    end
    tick(1);
    chk("drain_empty", 32'(bus.empty_o), 32'd1);
    chk("drain_count", 32'(bus.count_o), 32'd0);

    // 3: predicted taken, actually not taken -> redirect to fall-through, younger flushed
    drive(1'b1, 1'b1, 2'b11, 32'h104, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'b01, 32'h204, 1'b0, 1'b0, 32'h0);
    chk("mp1_count_before", 32'(bus.count_o), 32'd2);
    expect_upd(1'b0, 2'b11, 1'b1, 32'h104);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'hDEAD0);
    chk("mp1_count_after", 32'(bus.count_o), 32'd0);
    tick(1);

    // 4: predicted not taken, actually taken, with a same-cycle wrong-path push
    drive(1'b1, 1'b0, 2'b00, 32'h40, 1'b0, 1'b0, 32'h0);
    expect_upd(1'b1, 2'b00, 1'b1, 32'h800);
    drive(1'b1, 1'b1, 2'b10, 32'h999, 1'b1, 1'b1, 32'h800);
    chk("mp2_empty", 32'(bus.empty_o), 32'd1);
    tick(2);
    chk("mp2_empty_later", 32'(bus.empty_o), 32'd1);

    // 5: resolve on empty queue is ignored
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h5000);
    chk("empty_res_count", 32'(bus.count_o), 32'd0);
    chk("empty_res_upd_v", 32'(bus.upd_v_o), 32'd0);
    chk("empty_res_flush", 32'(bus.flush_o), 32'd0);
    // wrap: entry j has pred=j[0], id=j[1:0]; resolve each with the matching direction
    for (int j = 0; j < 3; j++) begin
      logic [31:0] jv;
      jv = 32'(j);
      drive(1'b1, jv[0], jv[1:0], 32'h1000 + jv, 1'b0, 1'b0, 32'h0);
    end
    for (int k = 0; k < 10; k++) begin
      logic [31:0] kv, nv;
      kv = 32'(k);
      nv = 32'(k + 3);
      expect_upd(kv[0], kv[1:0], 1'b0, 32'h0);
      drive(1'b1, nv[0], nv[1:0], 32'h1000 + nv, 1'b1, kv[0], 32'h0);
      chk("wrap_count", 32'(bus.count_o), 32'd3);
    end
    for (int k = 10; k < 13; k++) begin
      logic [31:0] kv;
      kv = 32'(k);
      expect_upd(kv[0], kv[1:0], 1'b0, 32'h0);
      drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, kv[0], 32'h0);
    end
    tick(1);
    chk("wrap_empty", 32'(bus.empty_o), 32'd1);

    // reset mid-operation clears held entries
    drive(1'b1, 1'b1, 2'b01, 32'h300, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 2'b01, 32'h304, 1'b0, 1'b0, 32'h0);
    chk("midrst_count_before", 32'(bus.count_o), 32'd2);
    reset = 1'b1;
    #1;
    chk("midrst_count", 32'(bus.count_o), 32'd0);
    chk("midrst_empty", 32'(bus.empty_o), 32'd1);
    tick(1);
    reset = 1'b0;
    tick(1);

`ifdef BRQ_STATS_EN
    // 6: 3 correct + 2 mispredicts since reset
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b11, 32'h600, 1'b0, 1'b0, 32'h0);
      expect_upd(1'b1, 2'b11, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h0);
    end
    drive(1'b1, 1'b0, 2'b00, 32'h700, 1'b0, 1'b0, 32'h0);
    expect_upd(1'b1, 2'b00, 1'b1, 32'hA00);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 32'hA00);
    drive(1'b1, 1'b1, 2'b10, 32'h710, 1'b0, 1'b0, 32'h0);
    expect_upd(1'b0, 2'b10, 1'b1, 32'h710);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 32'hB00);
    tick(1);
    chk("stat_res", bus.stat_res_o, 32'd5);
    chk("stat_miss", bus.stat_miss_o, 32'd2);
`endif

    tick(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
